// File: rtl/frame_scheduler.sv
// Frame scheduler: tick divider plus a stage sequencer (input, update, collide, commit)
// that handshakes with external workers, with overrun, timeout and collision status.
module frame_scheduler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 60,
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pause,
    input  logic       step,
    input  logic       clr_err,
    output logic       in_req,
    input  logic       in_done,
    output logic       upd_req,
    input  logic       upd_done,
    output logic       col_req,
    input  logic       col_done,
    input  logic       col_hit,
    output logic       tick,
    output logic       frame_done,
    output logic       busy,
    output logic [2:0] state,
    output logic [7:0] overrun_cnt,
    output logic       timeout_err,
    output logic       game_over
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam logic [19:0] DIV_LAST = 20'(DIV - 1);
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INPUT   = 3'd1,
        UPDATE  = 3'd2,
        COLLIDE = 3'd3,
        COMMIT  = 3'd4
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [19:0]    div_cnt;
    logic [WW-1:0]  wait_cnt;
    logic           start;
    logic           wait_exp;
    logic           to_set;
    logic           hit_set;
    logic           ovr_inc;

    assign tick       = en && !pause && (div_cnt == DIV_LAST);
    assign start      = !game_over && (tick || (en && pause && step));
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == COMMIT);
    assign state      = state_q;
    assign wait_exp   = (wait_cnt == WAIT_MAX);
    assign ovr_inc    = tick && busy;

    always_ff @(posedge clk) begin
        if (rst || !en)
            div_cnt <= '0;
        else if (!pause)
            div_cnt <= tick ? '0 : div_cnt + 20'd1;
    end

    // A done on the same cycle the wait counter expires takes priority.
    always_comb begin
        state_d = state_q;
        to_set  = 1'b0;
        hit_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = INPUT;
            end
            INPUT: begin
                if (in_done) begin
                    state_d = UPDATE;
                end else if (wait_exp) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
                end
            end
            UPDATE: begin
                if (upd_done) begin
                    state_d = COLLIDE;
                end else if (wait_exp) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
                end
            end
            COLLIDE: begin
                if (col_done) begin
                    state_d = COMMIT;
                    hit_set = col_hit;
                end else if (wait_exp) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            in_req  <= 1'b0;
            upd_req <= 1'b0;
            col_req <= 1'b0;
        end else begin
            state_q <= state_d;
            in_req  <= (state_d == INPUT);
            upd_req <= (state_d == UPDATE);
            col_req <= (state_d == COLLIDE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || state_d != state_q)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
            game_over   <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            timeout_err <= to_set || (timeout_err && !clr_err);
            game_over   <= hit_set || (game_over && !clr_err);
            if (ovr_inc)
                overrun_cnt <= (overrun_cnt == 8'hFF) ? 8'hFF : overrun_cnt + 8'd1;
            else if (clr_err)
                overrun_cnt <= '0;
        end
    end

endmodule
